// File: rtl/mem_wr_arbiter.sv
// mem_wr_arbiter: shares the async_mem write port between two packet producers.
// Packet-level round-robin arbitration, write address generation with wrap for
// any DEPTH >= 2, and full-based back-pressure from a wr_clk-synchronised read
// pointer. Optional per-producer beat counters when MEM_WR_ARB_STATS_EN is defined.
module mem_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  req0_valid,
  input  logic                  req0_last,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_last,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic [AW:0]           rd_ptr_sync,
  output logic                  mem_wr_en,
  output logic [AW-1:0]         mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [AW:0]           wr_ptr,
  output logic                  full,
`ifdef MEM_WR_ARB_STATS_EN
  input  logic                  stats_clr,
  output logic [15:0]           beats0,
  output logic [15:0]           beats1,
`endif
  output logic [1:0]            owner
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_last_grant, w_last_grant_nxt;
  logic [1:0]            r_owner, w_owner_nxt;
  logic [AW:0]           r_wr_ptr;
  logic                  r_mem_wr_en;
  logic [AW-1:0]         r_mem_wr_addr;
  logic [DATA_WIDTH-1:0] r_mem_wr_data;
  logic                  w_full, w_cand, w_sel;
  logic                  w_ready0, w_ready1, w_acc, w_acc_last;
  logic [DATA_WIDTH-1:0] w_acc_data;

  // Next pointer value: address wraps at DEPTH-1 and the wrap bit toggles.
  function automatic logic [AW:0] f_ptr_inc(input logic [AW:0] ptr);
    if (ptr[AW-1:0] == AW'(DEPTH - 1)) begin
      return {~ptr[AW], {AW{1'b0}}};
    end else begin
      return {ptr[AW], ptr[AW-1:0] + AW'(1)};
    end
  endfunction

  assign w_full = (r_wr_ptr[AW-1:0] == rd_ptr_sync[AW-1:0]) &&
                  (r_wr_ptr[AW] != rd_ptr_sync[AW]);

  // Pick the producer allowed to transfer this cycle (w_sel: 0 = producer 0, 1 = producer 1).
  always_comb begin
    w_cand = 1'b0;
    w_sel  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req0_valid && req1_valid) begin
          w_cand = 1'b1;
          w_sel  = ~r_last_grant;
        end else if (req0_valid) begin
          w_cand = 1'b1;
          w_sel  = 1'b0;
        end else if (req1_valid) begin
          w_cand = 1'b1;
          w_sel  = 1'b1;
        end else begin
          w_cand = 1'b0;
        end
      end
      S_OWN0: begin
        w_cand = 1'b1;
        w_sel  = 1'b0;
      end
      S_OWN1: begin
        w_cand = 1'b1;
        w_sel  = 1'b1;
      end
      default: begin
        w_cand = 1'b0;
      end
    endcase
  end

  // Readies are masked by reset so nothing can be accepted while wr_rst is high.
  assign w_ready0   = w_cand && !w_sel && !w_full && !wr_rst;
  assign w_ready1   = w_cand &&  w_sel && !w_full && !wr_rst;
  assign w_acc      = (w_ready0 && req0_valid) || (w_ready1 && req1_valid);
  assign w_acc_last = w_sel ? req1_last : req0_last;
  assign w_acc_data = w_sel ? req1_data : req0_data;

  // Next-state, round-robin memory and owner encoding.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_last_grant_nxt = w_sel;
          if (!w_acc_last) begin
            w_state_nxt = w_sel ? S_OWN1 : S_OWN0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_OWN0, S_OWN1: begin
        if (w_acc && w_acc_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    case (w_state_nxt)
      S_OWN0:  w_owner_nxt = 2'd1;
      S_OWN1:  w_owner_nxt = 2'd2;
      default: w_owner_nxt = 2'd0;
    endcase
  end

  // FSM state, last grant and registered owner.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_owner      <= w_owner_nxt;
    end
  end

  // Write pointer advance and one-cycle-latency memory write port.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_wr_ptr      <= '0;
      r_mem_wr_en   <= 1'b0;
      r_mem_wr_addr <= '0;
      r_mem_wr_data <= '0;
    end else if (w_acc) begin
      r_wr_ptr      <= f_ptr_inc(r_wr_ptr);
      r_mem_wr_en   <= 1'b1;
      r_mem_wr_addr <= r_wr_ptr[AW-1:0];
      r_mem_wr_data <= w_acc_data;
    end else begin
      r_mem_wr_en   <= 1'b0;
    end
  end

`ifdef MEM_WR_ARB_STATS_EN
  logic [15:0] r_beats0, r_beats1;

  // Saturating per-producer accepted-beat counters; stats_clr wins over a count.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      r_beats0 <= 16'd0;
      r_beats1 <= 16'd0;
    end else if (stats_clr) begin
      r_beats0 <= 16'd0;
      r_beats1 <= 16'd0;
    end else begin
      if (w_acc && !w_sel && (r_beats0 != 16'hFFFF)) begin
        r_beats0 <= r_beats0 + 16'd1;
      end
      if (w_acc && w_sel && (r_beats1 != 16'hFFFF)) begin
        r_beats1 <= r_beats1 + 16'd1;
      end
    end
  end

  assign beats0 = r_beats0;
  assign beats1 = r_beats1;
`endif

  assign req0_ready  = w_ready0;
  assign req1_ready  = w_ready1;
  assign full        = w_full;
  assign wr_ptr      = r_wr_ptr;
  assign mem_wr_en   = r_mem_wr_en;
  assign mem_wr_addr = r_mem_wr_addr;
  assign mem_wr_data = r_mem_wr_data;
  assign owner       = r_owner;

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Self-checking bench for mem_wr_arbiter: directed scenarios plus random traffic,
// all compared against a counter-based reference model of the arbiter.
module tb_mem_wr_arbiter;
  localparam int DW = 8;
  localparam int D  = 10;
  localparam int AW = $clog2(D);

  logic          wr_clk = 1'b0;
  logic          wr_rst = 1'b1;
  logic          req0_valid = 1'b0, req0_last = 1'b0;
  logic [DW-1:0] req0_data = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0, req1_last = 1'b0;
  logic [DW-1:0] req1_data = '0;
  logic          req1_ready;
  logic [AW:0]   rd_ptr_sync = '0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic [AW:0]   wr_ptr;
  logic          full;
  logic [1:0]    owner;
  logic          stats_clr = 1'b0;
`ifdef MEM_WR_ARB_STATS_EN
  logic [15:0]   beats0, beats1;
`endif

  mem_wr_arbiter #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst),
    .req0_valid(req0_valid), .req0_last(req0_last), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_last(req1_last), .req1_data(req1_data), .req1_ready(req1_ready),
    .rd_ptr_sync(rd_ptr_sync), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .wr_ptr(wr_ptr), .full(full),
`ifdef MEM_WR_ARB_STATS_EN
    .stats_clr(stats_clr), .beats0(beats0), .beats1(beats1),
`endif
    .owner(owner)
  );

  always #5 wr_clk = ~wr_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pointers as plain counts modulo 2*DEPTH.
  int wcnt, rcnt, own, lg, b0, b1;
  logic          exp_en;
  int            exp_addr;
  logic [DW-1:0] exp_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW:0] ptr_of(input int c);
    return (AW+1)'(((c / D) % 2) * (1 << AW) + (c % D));
  endfunction

  function automatic int occupancy();
    return (wcnt - rcnt + 2 * D) % (2 * D);
  endfunction

  task automatic model_reset();
    wcnt = 0; rcnt = 0; own = 0; lg = 1; b0 = 0; b1 = 0;
    exp_en = 1'b0; exp_addr = 0; exp_data = '0;
  endtask

  // Hold reset across an edge with both producers presenting beats.
  task automatic do_reset();
    wr_rst = 1'b1;
    req0_valid = 1'b1; req0_last = 1'b0; req0_data = 8'hEE;
    req1_valid = 1'b1; req1_last = 1'b0; req1_data = 8'hDD;
    #1;
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rdy1", 32'(req1_ready), 32'd0);
`ifdef MEM_WR_ARB_STATS_EN
    chk("rst_beats0", 32'(beats0), 32'd0);
    chk("rst_beats1", 32'(beats1), 32'd0);
`endif
    @(posedge wr_clk); #1;
    chk("rst_hold_wr_ptr", 32'(wr_ptr), 32'd0);
    chk("rst_hold_wr_en", 32'(mem_wr_en), 32'd0);
    wr_rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, check combinational outputs, clock, check registers.
  task automatic cycle(input logic v0, input logic l0, input logic [DW-1:0] d0,
                       input logic v1, input logic l1, input logic [DW-1:0] d1);
    logic mfull, e0, e1, acc0, acc1;
    req0_valid = v0; req0_last = l0; req0_data = d0;
    req1_valid = v1; req1_last = l1; req1_data = d1;
    rd_ptr_sync = ptr_of(rcnt);
    #1;
    mfull = (occupancy() == D);
    e0 = 1'b0; e1 = 1'b0;
    if (own == 1) e0 = !mfull;
    else if (own == 2) e1 = !mfull;
    else if (v0 && v1) begin
      if (lg == 0) e1 = !mfull; else e0 = !mfull;
    end
    else if (v0) e0 = !mfull;
    else if (v1) e1 = !mfull;
    chk("full", 32'(full), 32'(mfull));
    chk("ready0", 32'(req0_ready), 32'(e0));
    chk("ready1", 32'(req1_ready), 32'(e1));
    acc0 = e0 && v0;
    acc1 = e1 && v1;
    @(posedge wr_clk); #1;
    if (stats_clr) begin
      b0 = 0; b1 = 0;
    end else begin
      if (acc0 && b0 < 65535) b0++;
      if (acc1 && b1 < 65535) b1++;
    end
    if (acc0 || acc1) begin
      exp_en   = 1'b1;
      exp_addr = wcnt % D;
      exp_data = acc0 ? d0 : d1;
      wcnt     = (wcnt + 1) % (2 * D);
      if (own == 0) begin
        lg = acc0 ? 0 : 1;
        if (!(acc0 ? l0 : l1)) own = acc0 ? 1 : 2;
      end else if (acc0 ? l0 : l1) begin
        own = 0;
      end
    end else begin
      exp_en = 1'b0;
    end
    chk("mem_wr_en", 32'(mem_wr_en), 32'(exp_en));
    chk("mem_wr_addr", 32'(mem_wr_addr), 32'(exp_addr));
    chk("mem_wr_data", 32'(mem_wr_data), 32'(exp_data));
    chk("wr_ptr", 32'(wr_ptr), 32'(ptr_of(wcnt)));
    chk("owner", 32'(owner), 32'(own));
`ifdef MEM_WR_ARB_STATS_EN
    chk("beats0", 32'(beats0), 32'(b0));
    chk("beats1", 32'(beats1), 32'(b1));
`endif
  endtask

  initial begin
    model_reset();
    do_reset();

    // 3-beat packet from producer 0 while producer 1 is also valid.
    cycle(1'b1, 1'b0, 8'hA0, 1'b1, 1'b0, 8'hB0);
    cycle(1'b1, 1'b0, 8'hA1, 1'b1, 1'b0, 8'hB0);
    cycle(1'b1, 1'b1, 8'hA2, 1'b1, 1'b0, 8'hB0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    chk("pkt_last_addr", 32'(mem_wr_addr), 32'd2);

    // Continuous single-beat packets from both: grants alternate.
    for (int i = 0; i < 8; i++) begin
      rcnt = wcnt;
      cycle(1'b1, 1'b1, DW'(8'h10 + i), 1'b1, 1'b1, DW'(8'h20 + i));
    end

    // Fill with read pointer held at 0, then release three entries.
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, DW'(8'h30 + i), 1'b0, 1'b0, 8'h00);
    chk("full_ptr", 32'(wr_ptr), 32'(1 << AW));
    rcnt = 3;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, DW'(8'h40 + i), 1'b0, 1'b0, 8'h00);

    // Wrap through DEPTH-1 -> 0 with space maintained.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      rcnt = wcnt;
      cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, DW'(8'h50 + i));
    end

    // Producer 1 keeps ownership through a full stall, then finishes first.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, DW'(8'h60 + i), 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'h77, 1'b1, 1'b0, DW'(8'h80 + i));
    chk("stall_owner", 32'(owner), 32'd2);
    rcnt = 5;
    cycle(1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 8'h8F);
    cycle(1'b1, 1'b1, 8'h78, 1'b1, 1'b1, 8'h90);

    // Reset asserted while producer 0 owns a packet.
    do_reset();
    cycle(1'b1, 1'b0, 8'hC0, 1'b0, 1'b0, 8'h00);
    chk("own0_before_rst", 32'(owner), 32'd1);
    do_reset();

    // Random traffic with a randomly advancing read pointer.
    for (int i = 0; i < 400; i++) begin
      int occ, k;
      occ = occupancy();
      k = $urandom_range(0, (occ > 3) ? 3 : occ);
      if ($urandom_range(0, 2) == 0) k = 0;
      rcnt = (rcnt + k) % (2 * D);
      stats_clr = ($urandom_range(0, 49) == 0);
      cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), DW'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0), DW'($urandom));
    end
    stats_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_wr_arbiter.md
Name: mem_wr_arbiter

Overview:
- Single-clock, write-domain controller that shares the async_mem write port between two packet-oriented producers.
- Performs packet-level round-robin arbitration and generates the write address sequence, including wrap for non-power-of-two DEPTH.
- Stalls the producers when the memory is full, using a read pointer already synchronised into wr_clk.
- Drives mem_wr_en, mem_wr_addr and mem_wr_data directly into async_mem's wr_en, wr_addr and wr_data.

Parameters:
- DATA_WIDTH, 8, width of the data path; must match async_mem.
- DEPTH, 10, number of memory entries; any value of 2 or more. Derived localparam AW = clog2(DEPTH).

Ports:
- wr_clk  in  1  write-domain clock; all logic is on its rising edge.
- wr_rst  in  1  reset, asynchronous and active-high.
- req0_valid  in  1  producer 0 has a beat.
- req0_last  in  1  producer 0 beat is the last of its packet.
- req0_data  in  DATA_WIDTH  producer 0 beat data.
- req0_ready  out  1  producer 0 beat accepted this cycle.
- req1_valid, req1_last, req1_data, req1_ready  same as producer 0, for producer 1.
- rd_ptr_sync  in  AW+1  synchronised read pointer {wrap bit, address}, binary.
- mem_wr_en  out  1  write strobe to the memory.
- mem_wr_addr  out  AW  write address.
- mem_wr_data  out  DATA_WIDTH  write data.
- wr_ptr  out  AW+1  write pointer {wrap bit, address}, registered.
- full  out  1  memory full.
- owner  out  2  current packet owner: 0 = none, 1 = producer 0, 2 = producer 1.

Behaviour:
- Reset values:
  - mem_wr_en 0, mem_wr_addr 0, mem_wr_data 0, wr_ptr 0, owner 0.
  - last_grant set to 1, so producer 0 wins the first tie.
  - FSM in IDLE.
- full is combinational: asserted when wr_ptr[AW-1:0] equals rd_ptr_sync[AW-1:0] and the wrap bits differ.
- FSM states are IDLE, OWN0 and OWN1.
- IDLE:
  - The candidate is whichever producer is valid.
  - If both are valid, the candidate is the producer not equal to last_grant.
  - The candidate's ready equals !full.
  - If its first beat is accepted with last=0, move to OWN0 or OWN1. If accepted with last=1, stay in IDLE.
  - In either case, update last_grant to that producer.
- OWN0 / OWN1:
  - Only the owner's ready can be high (ready = !full). The other producer's ready is held at 0, even if it is valid.
  - Return to IDLE on an accepted beat with last=1.
  - Ownership is kept while full stalls the port.
- A beat is accepted when valid && ready. At most one beat is accepted per cycle.
- Write latency is 1 cycle. The cycle after an accept:
  - mem_wr_en=1;
  - mem_wr_addr = the address part of wr_ptr before the increment;
  - mem_wr_data = the accepted data.
  - Otherwise mem_wr_en=0 and the addr/data registers hold their values.
- Pointer increment on accept:
  - If address == DEPTH-1, the address goes to 0 and the wrap bit toggles.
  - Otherwise the address increments by 1.
- Simultaneous events:
  - A new accept may occur in the same cycle as the previous beat's registered write (back-to-back, 1 beat per clock).
  - full is re-evaluated each cycle from the updated wr_ptr.
- Reset mid-packet clears ownership immediately. A beat presented during reset is not accepted.
- ready outputs are combinational from valid, FSM state and full. No ready is ever asserted while wr_rst is high.

Optional Feature:
- Macro: MEM_WR_ARB_STATS_EN.
- When defined, adds outputs beats0 and beats1, each 16 bits.
  - They count accepted beats per producer and saturate at 16'hFFFF.
  - Both clear on wr_rst.
  - Adds input stats_clr (1 bit): synchronous clear, with priority over an increment in the same cycle.
- When undefined, these ports and their logic are absent and the behaviour is otherwise identical.

Test Plan:
- Reset with both producers valid, then release -> req0_ready=1 first. A 3-beat packet (0xA0..0xA2) is written at addr 0,1,2; mem_wr_en trails each accept by 1 cycle; req1_ready=0 throughout.
- Both valid with single-beat packets continuously -> grants alternate 0,1,0,1; wr_ptr advances 1 per clock.
- rd_ptr_sync held at 0, 10 beats written (DEPTH=10) -> wr_ptr={1,0}, full=1, ready low. rd_ptr_sync={0,3} -> full=0 and writes resume at addr 0.
- Wrap: 12 beats, with rd_ptr_sync advanced to keep space -> addresses 8,9,0,1 and the wrap bit toggles at the 9->0 step.
- Producer 1 owns a packet, full asserts mid-packet, producer 0 is valid -> owner stays 2. After space frees, producer 1 finishes its packet before producer 0 is granted.
- wr_rst pulsed during OWN0 -> owner=0, wr_ptr=0, mem_wr_en=0 asynchronously. With MEM_WR_ARB_STATS_EN defined, beats0 = beats1 = 0.
